// File: rtl/mandelbrot_pkg.sv
// Shared display constants, pixel format and colour helpers for the Mandelbrot display path.
// Default geometry is 640x480@60 from a 64x48 source upscaled 10x.
package mandelbrot_pkg;

    localparam int unsigned H_ACT   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned V_ACT   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

    localparam int unsigned SRC_W = 64;
    localparam int unsigned SRC_H = 48;
    localparam int unsigned SCALE = 10;
    localparam int unsigned AW    = $clog2(SRC_W * SRC_H);

    // Raster counter width, enough for H_TOTAL and V_TOTAL.
    localparam int unsigned CNT_W = 10;

    localparam int unsigned RGB_R_LSB = 6;
    localparam int unsigned RGB_G_LSB = 3;
    localparam int unsigned RGB_B_LSB = 0;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb333_t;

    function automatic logic [7:0] expand3to8(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Frame-store read port, buffer swap handshake and VGA pins of the scanout block.
interface fb_scanout_if #(
    parameter int unsigned AW = mandelbrot_pkg::AW
);
    logic          rd_en;
    logic [AW:0]   rd_addr;
    logic [8:0]    rd_data;
    logic          swap_req;
    logic          swap_ack;
    logic          front_buf;
    logic          frame_start;
    logic          vga_hs;
    logic          vga_vs;
    logic          vga_blank_n;
    logic [7:0]    vga_r;
    logic [7:0]    vga_g;
    logic [7:0]    vga_b;

    modport master (
        output rd_en, rd_addr, swap_ack, front_buf, frame_start,
        output vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
        input  rd_data, swap_req
    );

    modport slave (
        input  rd_en, rd_addr, swap_ack, front_buf, frame_start,
        input  vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
        output rd_data, swap_req
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters and undelayed sync/active flags; also exposes next-state counters
// so the fetch stage can run one pixel ahead.
module vga_timing_gen
    import mandelbrot_pkg::*;
#(
    parameter int unsigned H_ACT  = mandelbrot_pkg::H_ACT,
    parameter int unsigned H_FP   = mandelbrot_pkg::H_FP,
    parameter int unsigned H_SYNC = mandelbrot_pkg::H_SYNC,
    parameter int unsigned H_BP   = mandelbrot_pkg::H_BP,
    parameter int unsigned V_ACT  = mandelbrot_pkg::V_ACT,
    parameter int unsigned V_FP   = mandelbrot_pkg::V_FP,
    parameter int unsigned V_SYNC = mandelbrot_pkg::V_SYNC,
    parameter int unsigned V_BP   = mandelbrot_pkg::V_BP
) (
    input  logic             clk_in,
    input  logic             reset,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic [CNT_W-1:0] h_nxt,
    output logic [CNT_W-1:0] v_nxt,
    output logic             active,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] HActC  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] HsBeg  = CNT_W'(H_ACT + H_FP);
    localparam logic [CNT_W-1:0] HsEnd  = CNT_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] HLast  = CNT_W'(H_ACT + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] VActC  = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] VsBeg  = CNT_W'(V_ACT + V_FP);
    localparam logic [CNT_W-1:0] VsEnd  = CNT_W'(V_ACT + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] VLast  = CNT_W'(V_ACT + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] h_q, v_q;
    logic             fs_q;

    always_comb begin
        h_nxt = h_q + 1'b1;
        v_nxt = v_q;
        if (h_q == HLast) begin
            h_nxt = '0;
            v_nxt = (v_q == VLast) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            h_q  <= '0;
            v_q  <= '0;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_nxt;
            v_q  <= v_nxt;
            fs_q <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign frame_start = fs_q;
    assign active      = (h_q < HActC) && (v_q < VActC);
    assign hs_raw      = !((h_q >= HsBeg) && (h_q < HsEnd));
    assign vs_raw      = !((v_q >= VsBeg) && (v_q < VsEnd));

endmodule

// File: rtl/fb_scanout.sv
// Read side of the double-buffered frame store: fetches, upscales and drives the VGA DAC,
// granting buffer swaps only on the first front-porch line.
module fb_scanout
    import mandelbrot_pkg::*;
#(
    parameter int unsigned SRC_W  = mandelbrot_pkg::SRC_W,
    parameter int unsigned SRC_H  = mandelbrot_pkg::SRC_H,
    parameter int unsigned SCALE  = mandelbrot_pkg::SCALE,
    parameter int unsigned H_ACT  = mandelbrot_pkg::H_ACT,
    parameter int unsigned H_FP   = mandelbrot_pkg::H_FP,
    parameter int unsigned H_SYNC = mandelbrot_pkg::H_SYNC,
    parameter int unsigned H_BP   = mandelbrot_pkg::H_BP,
    parameter int unsigned V_ACT  = mandelbrot_pkg::V_ACT,
    parameter int unsigned V_FP   = mandelbrot_pkg::V_FP,
    parameter int unsigned V_SYNC = mandelbrot_pkg::V_SYNC,
    parameter int unsigned V_BP   = mandelbrot_pkg::V_BP,
    parameter int unsigned AW     = mandelbrot_pkg::AW
) (
    input  logic         clk_in,
    input  logic         reset,
    fb_scanout_if.master bus
);

    localparam int unsigned XW = $clog2(SRC_W);
    localparam int unsigned YW = $clog2(SRC_H);
    localparam int unsigned SW = $clog2(SCALE);
    localparam logic [SW-1:0]    SubLast = SW'(SCALE - 1);
    localparam logic [CNT_W-1:0] HActC   = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] VActC   = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] HLast   = CNT_W'(H_ACT + H_FP + H_SYNC + H_BP - 1);

    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic             active, hs_raw, vs_raw, frame_start;

    vga_timing_gen #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_in     (clk_in),
        .reset      (reset),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .h_nxt      (h_nxt),
        .v_nxt      (v_nxt),
        .active     (active),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .frame_start(frame_start)
    );

    logic [SW-1:0] h_sub_q, h_sub_d, v_sub_q, v_sub_d;
    logic [XW-1:0] x_src_q, x_src_d;
    logic [YW-1:0] y_src_q, y_src_d;
    logic [AW-1:0] word_addr;
    logic          active_nxt, fetch, swap_now;
    logic          rd_en_q, rd_valid_q, front_buf_q, swap_ack_q;
    logic [AW:0]   rd_addr_q;
    logic [8:0]    hold_q;
    rgb333_t       pix;
    logic          active_d1, hs_d1, vs_d1, blank_n_q, hs_q, vs_q;
    logic [7:0]    r_q, g_q, b_q;

    // Sub-counters track the current raster position; their _d values describe the next one.
    always_comb begin
        h_sub_d = h_sub_q;
        x_src_d = x_src_q;
        v_sub_d = v_sub_q;
        y_src_d = y_src_q;
        if (h_cnt == HActC) begin
            h_sub_d = '0;
            x_src_d = '0;
        end else if (active) begin
            h_sub_d = (h_sub_q == SubLast) ? '0 : h_sub_q + 1'b1;
            if (h_sub_q == SubLast) x_src_d = x_src_q + 1'b1;
        end
        if (v_cnt == VActC) begin
            v_sub_d = '0;
            y_src_d = '0;
        end else if ((v_cnt < VActC) && (h_cnt == HLast)) begin
            v_sub_d = (v_sub_q == SubLast) ? '0 : v_sub_q + 1'b1;
            if (v_sub_q == SubLast) y_src_d = y_src_q + 1'b1;
        end
    end

    // Reads are issued one pixel ahead so RAM latency plus the output register give 2 cycles.
    // After reset the (0,0) read was never issued, so fetch the first word one pixel late.
    always_comb begin
        active_nxt = (h_nxt < HActC) && (v_nxt < VActC);
        fetch      = active_nxt && ((h_sub_d == '0) ||
                     ((h_cnt == '0) && (v_cnt == '0) && !rd_en_q));
        word_addr  = AW'(y_src_d) * AW'(SRC_W) + AW'(x_src_d);
        swap_now   = (h_cnt == '0) && (v_cnt == VActC) && bus.swap_req;
        pix        = rgb333_t'(rd_valid_q ? bus.rd_data : hold_q);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            h_sub_q     <= '0;
            x_src_q     <= '0;
            v_sub_q     <= '0;
            y_src_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            hold_q      <= '0;
            front_buf_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            active_d1   <= 1'b0;
            hs_d1       <= 1'b1;
            vs_d1       <= 1'b1;
            blank_n_q   <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else begin
            h_sub_q    <= h_sub_d;
            x_src_q    <= x_src_d;
            v_sub_q    <= v_sub_d;
            y_src_q    <= y_src_d;
            rd_en_q    <= fetch;
            if (fetch) rd_addr_q <= {front_buf_q, word_addr};
            rd_valid_q <= rd_en_q;
            if (rd_valid_q) hold_q <= bus.rd_data;
            swap_ack_q <= swap_now;
            if (swap_now) front_buf_q <= ~front_buf_q;
            active_d1  <= active;
            hs_d1      <= hs_raw;
            vs_d1      <= vs_raw;
            blank_n_q  <= active_d1;
            hs_q       <= hs_d1;
            vs_q       <= vs_d1;
            r_q        <= active_d1 ? expand3to8(pix.r) : 8'h00;
            g_q        <= active_d1 ? expand3to8(pix.g) : 8'h00;
            b_q        <= active_d1 ? expand3to8(pix.b) : 8'h00;
        end
    end

    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.swap_ack    = swap_ack_q;
    assign bus.front_buf   = front_buf_q;
    assign bus.frame_start = frame_start;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_blank_n = blank_n_q;
    assign bus.vga_r       = r_q;
    assign bus.vga_g       = g_q;
    assign bus.vga_b       = b_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a reduced 4x3 source, 2x scale, 15x11 raster
// (frame = 165 cycles) so several whole frames fit in a short run.
module tb_fb_scanout;

    localparam int SRC_W = 4, SRC_H = 3, SCALE = 2;
    localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
    localparam int V_ACT = 6, V_FP = 2, V_SYNC = 1, V_BP = 2;
    localparam int AW = 4;
    localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FRAME = HT * VT;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #20 clk_in = ~clk_in;

    fb_scanout_if #(.AW(AW)) bus();

    fb_scanout #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE),
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .AW(AW)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    logic [8:0]  mem [0:31];
    logic [23:0] rgb;
    assign rgb = {bus.vga_r, bus.vga_g, bus.vga_b};

    always @(posedge clk_in) begin
        if (reset) bus.rd_data <= '0;
        else if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // Reference raster position, aligned with the DUT counters in the same cycle.
    int pos_h = 0, pos_v = 0;
    always @(posedge clk_in) begin
        if (reset) begin
            pos_h <= 0;
            pos_v <= 0;
        end else if (pos_h == HT - 1) begin
            pos_h <= 0;
            pos_v <= (pos_v == VT - 1) ? 0 : pos_v + 1;
        end else begin
            pos_h <= pos_h + 1;
        end
    end

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        @(negedge clk_in);
        while (!(pos_h == h && pos_v == v) && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 2000) check("wait_pos_timeout", n, 0);
    endtask

    task automatic count_window(input int n, output int hs_low, output int vs_low,
                                output int blank_hi, output int hs_falls,
                                output int vs_falls, output int acks);
        logic hs_p, vs_p;
        hs_p = bus.vga_hs;
        vs_p = bus.vga_vs;
        hs_low = 0; vs_low = 0; blank_hi = 0; hs_falls = 0; vs_falls = 0; acks = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (!bus.vga_hs) hs_low++;
            if (!bus.vga_vs) vs_low++;
            if (bus.vga_blank_n) blank_hi++;
            if (hs_p && !bus.vga_hs) hs_falls++;
            if (vs_p && !bus.vga_vs) vs_falls++;
            if (bus.swap_ack) acks++;
            hs_p = bus.vga_hs;
            vs_p = bus.vga_vs;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sync"}, {bus.vga_hs, bus.vga_vs, bus.vga_blank_n}, 3'b110);
        check({tag, "_ctrl"}, {bus.rd_en, bus.swap_ack, bus.front_buf, bus.frame_start}, 4'b0000);
        check({tag, "_addr"}, bus.rd_addr, 0);
        check({tag, "_rgb"}, rgb, 0);
    endtask

    int hl, vl, bh, hf, vf, ak;

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = (i < 16) ? 9'(i) : (9'h150 ^ 9'(i - 16));
        mem[0] = 9'h1FF;
        mem[1] = 9'h000;
        bus.swap_req = 1'b0;

        repeat (3) @(negedge clk_in);
        check_reset_state("rst");
        reset = 1'b0;

        // Second frame: first frame_start after reset, clean pipeline
        wait_pos(0, 0);
        check("fs_pulse", bus.frame_start, 1);
        check("fetch_w0", {bus.rd_en, bus.rd_addr}, {1'b1, 5'd0});
        wait_pos(1, 0);
        check("fs_single", {bus.frame_start, bus.rd_en}, 2'b00);
        wait_pos(2, 0);
        check("px00_white", {bus.vga_blank_n, rgb}, {1'b1, 24'hFFFFFF});
        check("fetch_w1", {bus.rd_en, bus.rd_addr}, {1'b1, 5'd1});
        wait_pos(3, 0);
        check("px10_hold", rgb, 24'hFFFFFF);
        wait_pos(4, 0);
        check("px20_black", {bus.vga_blank_n, rgb}, {1'b1, 24'h000000});
        wait_pos(8, 0);
        check("px60_w3", rgb, 24'h00006D);
        wait_pos(10, 0);
        check("hblank_rgb0", {bus.vga_blank_n, rgb}, 25'd0);
        wait_pos(11, 0);
        check("hs_pre", bus.vga_hs, 1);
        wait_pos(12, 0);
        check("hs_first", bus.vga_hs, 0);
        wait_pos(14, 0);
        check("hs_last", bus.vga_hs, 0);
        wait_pos(0, 1);
        check("hs_post", bus.vga_hs, 1);
        wait_pos(0, 2);
        check("fetch_line2", {bus.rd_en, bus.rd_addr}, {1'b1, 5'd4});
        wait_pos(2, 2);
        check("px02_w4", rgb, 24'h000092);
        wait_pos(9, 3);
        check("px73_w7", rgb, 24'h0000FF);
        wait_pos(2, 5);
        check("px05_w8", rgb, 24'h002400);
        wait_pos(2, 6);
        check("vblank_rgb0", {bus.vga_blank_n, rgb}, 25'd0);
        wait_pos(1, 8);
        check("vs_pre", bus.vga_vs, 1);
        wait_pos(2, 8);
        check("vs_first", bus.vga_vs, 0);
        wait_pos(1, 9);
        check("vs_last", bus.vga_vs, 0);
        wait_pos(2, 9);
        check("vs_post", bus.vga_vs, 1);

        // Two whole frames of sync/blank statistics
        wait_pos(0, 0);
        count_window(2 * FRAME, hl, vl, bh, hf, vf, ak);
        check("hs_low_2f", hl, 2 * VT * H_SYNC);
        check("hs_periods", hf, 2 * VT);
        check("vs_low_2f", vl, 2 * V_SYNC * HT);
        check("vs_periods", vf, 2);
        check("blank_2f", bh, 2 * H_ACT * V_ACT);
        check("no_req_no_ack", ak, 0);
        count_window(HT, hl, vl, bh, hf, vf, ak);
        check("blank_line", bh, H_ACT);

        // Mid-frame request granted at the first front-porch line
        wait_pos(0, 3);
        bus.swap_req = 1'b1;
        wait_pos(0, 6);
        check("swap_wait", {bus.swap_ack, bus.front_buf}, 2'b00);
        wait_pos(1, 6);
        check("swap_grant", {bus.swap_ack, bus.front_buf}, 2'b11);
        bus.swap_req = 1'b0;
        wait_pos(2, 6);
        check("swap_pulse1", bus.swap_ack, 0);
        wait_pos(0, 0);
        check("fetch_buf1", {bus.rd_en, bus.rd_addr}, {1'b1, 5'd16});
        wait_pos(2, 0);
        check("px00_buf1", rgb, 24'hB64900);

        // Held request: exactly one grant per frame
        bus.swap_req = 1'b1;
        count_window(3 * FRAME, hl, vl, bh, hf, vf, ak);
        bus.swap_req = 1'b0;
        check("held_acks", ak, 3);
        check("held_front", bus.front_buf, 0);

        // Late request waits for the next frame's sampling point
        wait_pos(0, 7);
        bus.swap_req = 1'b1;
        count_window(150, hl, vl, bh, hf, vf, ak);
        check("late_no_ack", ak, 0);
        wait_pos(1, 6);
        check("late_grant", {bus.swap_ack, bus.front_buf}, 2'b11);
        bus.swap_req = 1'b0;

        // One-cycle reset in the middle of a frame
        wait_pos(5, 3);
        reset = 1'b1;
        @(negedge clk_in);
        check_reset_state("midrst");
        reset = 1'b0;
        wait_pos(1, 0);
        check("rst_fetch0", {bus.rd_en, bus.rd_addr, bus.vga_blank_n}, {1'b1, 5'd0, 1'b0});
        wait_pos(2, 0);
        check("rst_blank_on", bus.vga_blank_n, 1);
        wait_pos(3, 0);
        check("rst_px10", rgb, 24'hFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
